// File: rtl/nn_io_pkg.sv
// Shared defaults and loader FSM state type for the MNIST input/output RAM.
package nn_io_pkg;

    localparam int ADDR_W_DEF      = 10;
    localparam int DATA_W_DEF      = 16;
    localparam int FRAME_LEN_MNIST = 784;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } io_state_e;

endpackage

// File: rtl/ram_io_loader.sv
// Stream-to-RAM frame loader; passes the inference read address through while idle.
// Define IO_LOADER_CHECKSUM_EN to build the running checksum of accepted words.
module ram_io_loader
    import nn_io_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BASE_ADDR = 0,
    parameter int FRAME_LEN = FRAME_LEN_MNIST
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [ADDR_W-1:0] Ext_Address,
    output logic [ADDR_W-1:0] Ram_Address,
    output logic [DATA_W-1:0] Ram_Data,
    output logic              Ram_Wren,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W:0]   Word_Count,
    output logic [DATA_W-1:0] Checksum
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(FRAME_LEN - 1);

    generate
        if (FRAME_LEN == 0 || BASE_ADDR + FRAME_LEN > (1 << ADDR_W)) begin : g_bad_cfg
            $error("ram_io_loader: frame does not fit in the RAM address space");
        end
    endgenerate

    io_state_e         state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              wr_pend_q, wr_pend_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        In_Ready  = 1'b0;
        Done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    // Word is written one cycle later at its pre-increment index.
                    wr_pend_d = 1'b1;
                    wr_addr_d = BASE + count_q[ADDR_W-1:0];
                    wr_data_d = In_Data;
                    count_d   = count_q + (ADDR_W+1)'(1);
                    if (count_q == LAST_IDX) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The shared RAM port belongs to the inference datapath unless a write is in flight.
    assign Ram_Wren    = wr_pend_q;
    assign Ram_Address = wr_pend_q ? wr_addr_q : Ext_Address;
    assign Ram_Data    = wr_pend_q ? wr_data_q : '0;
    assign Busy        = (state_q != IDLE);
    assign Word_Count  = count_q;

`ifdef IO_LOADER_CHECKSUM_EN
    logic              accept;
    logic [DATA_W-1:0] sum_q, sum_d;

    assign accept = (state_q == LOAD) && In_Valid;

    always_comb begin
        sum_d = sum_q;
        if (state_q == IDLE && Start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + In_Data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign Checksum = sum_q;
`else
    assign Checksum = '0;
`endif

endmodule

// File: tb/tb_ram_io_loader.sv
// Randomized scoreboard bench for ram_io_loader: default MNIST frame plus a small
// BASE_ADDR=200 / FRAME_LEN=10 instance.
module tb_ram_io_loader;

    localparam int AW     = 10;
    localparam int DW     = 16;
    localparam int FL     = 784;
    localparam int S_BASE = 200;
    localparam int S_LEN  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, in_valid, in_ready, ram_wren, busy, done;
    logic [DW-1:0] in_data, ram_data, checksum;
    logic [AW-1:0] ext_addr, ram_addr;
    logic [AW:0]   word_count;

    logic          s_start, s_in_valid, s_in_ready, s_ram_wren, s_busy, s_done;
    logic [DW-1:0] s_in_data, s_ram_data, s_checksum;
    logic [AW-1:0] s_ext_addr, s_ram_addr;
    logic [AW:0]   s_word_count;

    ram_io_loader u_dut (
        .Clk(clk), .Reset(rst), .Start(start), .In_Data(in_data), .In_Valid(in_valid),
        .In_Ready(in_ready), .Ext_Address(ext_addr), .Ram_Address(ram_addr),
        .Ram_Data(ram_data), .Ram_Wren(ram_wren), .Busy(busy), .Done(done),
        .Word_Count(word_count), .Checksum(checksum)
    );

    ram_io_loader #(.BASE_ADDR(S_BASE), .FRAME_LEN(S_LEN)) u_small (
        .Clk(clk), .Reset(rst), .Start(s_start), .In_Data(s_in_data), .In_Valid(s_in_valid),
        .In_Ready(s_in_ready), .Ext_Address(s_ext_addr), .Ram_Address(s_ram_addr),
        .Ram_Data(s_ram_data), .Ram_Wren(s_ram_wren), .Busy(s_busy), .Done(s_done),
        .Word_Count(s_word_count), .Checksum(s_checksum)
    );

    typedef struct { int addr; int data; bit last; } wr_t;
    typedef struct { int count; int sum; } fin_t;

    wr_t  exp_q[$];
    wr_t  s_exp_q[$];
    fin_t fin_q[$];
    int   ram_img[1024];
    int   exp_img[1024];
    int   wr_cnt[1024];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got 0x%0h, want no event", name, act);
    endtask

    function automatic logic [31:0] cks(input int sum);
`ifdef IO_LOADER_CHECKSUM_EN
        return sum & 32'hFFFF;
`else
        return (sum & 0);
`endif
    endfunction

    task automatic check_image(input string name);
        int n = 0;
        for (int a = 0; a < FL; a++) begin
            if (ram_img[a] != exp_img[a] || wr_cnt[a] != 1) n++;
        end
        check(name, n, 0);
    endtask

    // Monitor for the main instance: every write must be the next expected one.
    always @(negedge clk) begin
        wr_t  e;
        fin_t f;
        if (ram_wren) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_write", 32'(ram_addr));
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", ram_addr, e.addr);
                check("wr_data", ram_data, e.data);
                check("done_with_last", done, 32'(e.last));
            end
            ram_img[ram_addr] = int'(ram_data);
            wr_cnt[ram_addr]++;
        end else begin
            check("idle_passthru", ram_addr, ext_addr);
            check("idle_data_zero", ram_data, 0);
            if (done) fail_now("done_without_write", 32'(done));
        end
        if (done) begin
            if (fin_q.size() == 0) begin
                fail_now("unexpected_done", 32'(word_count));
            end else begin
                f = fin_q.pop_front();
                check("final_count", word_count, f.count);
                check("final_checksum", checksum, cks(f.sum));
            end
        end
    end

    // Monitor for the small instance.
    always @(negedge clk) begin
        wr_t se;
        if (s_ram_wren) begin
            if (s_exp_q.size() == 0) begin
                fail_now("s_unexpected_write", 32'(s_ram_addr));
            end else begin
                se = s_exp_q.pop_front();
                check("s_wr_addr", s_ram_addr, se.addr);
                check("s_wr_data", s_ram_data, se.data);
                check("s_done_with_last", s_done, 32'(se.last));
            end
        end else if (s_done) begin
            fail_now("s_done_without_write", 32'(s_done));
        end
    end

    // Called #1 after a rising edge with the loader idle.
    task automatic run_frame(input int gap_pct, input bit rnd_data, input int abort_after);
        int            sent = 0;
        int            sum  = 0;
        logic [DW-1:0] w;
        for (int a = 0; a < 1024; a++) wr_cnt[a] = 0;
        start    = 1'b1;
        in_valid = 1'($urandom_range(1));
        in_data  = DW'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("count_cleared", word_count, 0);
        check("checksum_cleared", checksum, 0);
        while (sent < FL) begin
            ext_addr = AW'($urandom);
            start    = (sent == 300);
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end else begin
                w        = rnd_data ? DW'($urandom) : DW'(sent);
                in_valid = 1'b1;
                in_data  = w;
                exp_q.push_back('{addr: sent, data: int'(w), last: (sent == FL - 1)});
                exp_img[sent] = int'(w);
                sum += int'(w);
                sent++;
                if (sent == FL) fin_q.push_back('{count: FL, sum: sum});
            end
            @(posedge clk); #1;
            if (abort_after != 0 && sent == abort_after && in_valid) begin
                exp_q.delete();
                rst = 1'b1;
                #1;
                check("abort_wren_low", ram_wren, 0);
                check("abort_busy", busy, 0);
                check("abort_ready", in_ready, 0);
                check("abort_done", done, 0);
                check("abort_count", word_count, 0);
                in_valid = 1'b0;
                start    = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                check("abort_dropped_write", wr_cnt[abort_after - 1], 0);
                check("abort_partial_kept", wr_cnt[abort_after - 2], 1);
                @(posedge clk); #1;
                return;
            end
        end
        check("done_pulse", done, 1);
        check("done_ready_low", in_ready, 0);
        check("done_busy", busy, 1);
        check("done_count", word_count, FL);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle_after_done", busy, 0);
            check("idle_no_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("count_held", word_count, FL);
        check("checksum_held", checksum, cks(sum));
        check_image("frame_image");
    endtask

    initial begin
        logic [DW-1:0] w;
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        ext_addr   = 10'h155;
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        s_in_data  = '0;
        s_ext_addr = '0;
        #2;
        check("rst_ready", in_ready, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_data", ram_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", word_count, 0);
        check("rst_checksum", checksum, 0);
        check("rst_addr", ram_addr, 10'h155);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(0, 1'b0, 0);

        for (int a = 0; a < 1024; a += 2) begin
            ext_addr = AW'(a);
            #2;
            check("sweep_addr", ram_addr, a);
            check("sweep_wren", ram_wren, 0);
            #4;
            ext_addr = AW'(a + 1);
            #2;
            check("sweep_addr", ram_addr, a + 1);
            check("sweep_wren", ram_wren, 0);
            @(posedge clk); #1;
        end

        run_frame(50, 1'b1, 0);
        run_frame(30, 1'b1, 100);
        run_frame(20, 1'b1, 0);

        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < S_LEN; i++) begin
            w          = DW'($urandom);
            s_in_valid = 1'b1;
            s_in_data  = w;
            s_ext_addr = AW'($urandom);
            s_exp_q.push_back('{addr: S_BASE + i, data: int'(w), last: (i == S_LEN - 1)});
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        check("s_done_pulse", s_done, 1);
        check("s_count", s_word_count, S_LEN);
        @(posedge clk); #1;
        check("s_ready_low", s_in_ready, 0);
        check("s_idle", s_busy, 0);
        repeat (2) @(posedge clk);
        #1;

        check("pending_writes_left", exp_q.size(), 0);
        check("pending_done_left", fin_q.size(), 0);
        check("s_pending_writes_left", s_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
